// File: rtl/grad_batch_accumulator_if.sv
// rtl/grad_batch_accumulator_if.sv - gradient input/output stream bundle for grad_batch_accumulator
interface grad_batch_accumulator_if #(
    parameter int IDX_W = 2
) ();
    logic             grad_valid_in;
    logic [15:0]      grad_in;
    logic             grad_ready_out;
    logic [15:0]      grad_out;
    logic [IDX_W-1:0] grad_out_idx;
    logic             grad_out_valid;
    logic             grad_out_ready_in;

    // Producer of input beats and consumer of reduced gradients
    modport master (
        output grad_valid_in,
        output grad_in,
        input  grad_ready_out,
        input  grad_out,
        input  grad_out_idx,
        input  grad_out_valid,
        output grad_out_ready_in
    );

    // The accumulator itself
    modport slave (
        input  grad_valid_in,
        input  grad_in,
        output grad_ready_out,
        output grad_out,
        output grad_out_idx,
        output grad_out_valid,
        input  grad_out_ready_in
    );
endinterface

// File: rtl/grad_batch_accumulator.sv
// rtl/grad_batch_accumulator.sv - saturating batch accumulator of Q8.8 gradients with shift averaging
module grad_batch_accumulator #(
    parameter int N_ELEM  = 4,
    parameter int IDX_W   = 2,
    parameter int BATCH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic [BATCH_W-1:0] batch_size_in,
    input  logic [3:0]         avg_shift_in,
    grad_batch_accumulator_if.slave bus,
    output logic               busy_out,
    output logic               done_out,
    output logic               sat_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BATCH_W-1:0] batch_q;
    logic [3:0]         shift_q;
    logic [IDX_W-1:0]   elem_cnt;
    logic [BATCH_W-1:0] sample_cnt;
    logic [IDX_W-1:0]   emit_idx;
    logic signed [15:0] acc [N_ELEM];
    logic               sat_q;
    logic               done_q;

    logic               start_go;
    logic               start_zero;
    logic               accept;
    logic               emit_hs;
    logic               elem_last;
    logic               sample_last;
    logic               emit_last;
    logic signed [15:0] acc_cur;
    logic signed [16:0] sum17;
    logic               sat_hit;
    logic signed [15:0] sat_val;
    logic signed [15:0] emit_acc;
    logic signed [15:0] emit_shifted;

    // Handshake qualifiers and the saturating adder for the element being accumulated
    always_comb begin
        start_go    = (state_q == IDLE) && start_in && (batch_size_in != '0);
        start_zero  = (state_q == IDLE) && start_in && (batch_size_in == '0);
        accept      = (state_q == ACCUM) && bus.grad_valid_in;
        emit_hs     = (state_q == EMIT) && bus.grad_out_ready_in;
        elem_last   = (elem_cnt == IDX_W'(N_ELEM - 1));
        sample_last = (sample_cnt == (batch_q - BATCH_W'(1)));
        emit_last   = (emit_idx == IDX_W'(N_ELEM - 1));
        acc_cur     = acc[elem_cnt];
        sum17       = {acc_cur[15], acc_cur} + {bus.grad_in[15], bus.grad_in};
        // Overflow of the 16-bit result shows as the two top bits of the 17-bit sum disagreeing
        sat_hit     = sum17[16] ^ sum17[15];
        if (sat_hit) begin
            sat_val = sum17[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            sat_val = sum17[15:0];
        end
        emit_acc     = acc[emit_idx];
        emit_shifted = emit_acc >>> shift_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && elem_last && sample_last) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (emit_hs && emit_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch, accumulators, counters, sticky saturation flag and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batch_q    <= '0;
            shift_q    <= '0;
            elem_cnt   <= '0;
            sample_cnt <= '0;
            emit_idx   <= '0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done_q <= start_zero || (emit_hs && emit_last);
            if (start_go) begin
                batch_q    <= batch_size_in;
                shift_q    <= avg_shift_in;
                elem_cnt   <= '0;
                sample_cnt <= '0;
                emit_idx   <= '0;
                sat_q      <= 1'b0;
                for (int i = 0; i < N_ELEM; i++) begin
                    acc[i] <= '0;
                end
            end
            if (accept) begin
                acc[elem_cnt] <= sat_val;
                if (sat_hit) begin
                    sat_q <= 1'b1;
                end
                if (elem_last) begin
                    elem_cnt   <= '0;
                    sample_cnt <= sample_cnt + BATCH_W'(1);
                    emit_idx   <= '0;
                end else begin
                    elem_cnt <= elem_cnt + IDX_W'(1);
                end
            end
            if (emit_hs) begin
                if (emit_last) begin
                    emit_idx <= '0;
                end else begin
                    emit_idx <= emit_idx + IDX_W'(1);
                end
            end
        end
    end

    // Outputs decode purely from registered state
    always_comb begin
        bus.grad_ready_out = (state_q == ACCUM);
        bus.grad_out_valid = (state_q == EMIT);
        bus.grad_out       = (state_q == EMIT) ? emit_shifted : 16'h0000;
        bus.grad_out_idx   = (state_q == EMIT) ? emit_idx : '0;
        busy_out           = (state_q != IDLE);
        done_out           = done_q;
        sat_out            = sat_q;
    end

endmodule
